type_tracker: RTL and testbench
===============================

TYPE_TRACKER -- requirements
Module: type_tracker

Interface
REQ-001 SHALL have parameter LEN, default 25, meaning number of 5-bit letter slots in the target text.
REQ-002 SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value (nonzero).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to generate a new target text.
REQ-006 SHALL have port key_valid  input  1  single-cycle key event strobe.
REQ-007 SHALL have port key_code  input  5  typed letter, 0=A .. 25=Z; 26..31 are invalid codes.
REQ-008 SHALL have port key_bksp  input  1  qualifies key_valid as a backspace; key_code ignored when high.
REQ-009 SHALL have port text  output  5*LEN  target letters, slot i at bits [5i+4:5i], 0=A; feeds the text renderer directly.
REQ-010 SHALL have port cursor  output  5  index of the next slot to be typed.
REQ-011 SHALL have port err_mask  output  LEN  bit i set when slot i was typed wrong.
REQ-012 SHALL have port err_cnt  output  8  total wrong keystrokes this round, saturating.
REQ-013 SHALL have port busy  output  1  high while text generation is in progress.
REQ-014 SHALL have port done  output  1  high while the round is complete.

Function
REQ-015 SHALL implement states IDLE, GEN, TYPE, DONE; all outputs registered.
REQ-016 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every non-reset cycle in all states.
REQ-017 start in IDLE or DONE SHALL enter GEN next cycle, clearing cursor, err_mask, err_cnt, done; start in GEN or TYPE SHALL be ignored.
REQ-018 GEN SHALL last exactly LEN cycles; cycle k writes slot k = lfsr[4:0] if < 26, else lfsr[4:0]-26; other slots retain their value until written.
REQ-019 After the write of slot LEN-1, GEN SHALL go to TYPE; busy high exactly during GEN.
REQ-020 In TYPE, key_valid with key_bksp=0 SHALL compare key_code to slot[cursor]; on mismatch (including codes 26..31) set err_mask[cursor] and increment err_cnt; then cursor+1.
REQ-021 err_cnt SHALL saturate at 255.
REQ-022 A non-backspace key at cursor=LEN-1 SHALL be scored per REQ-020, then go to DONE with cursor=LEN and done=1 on the following cycle.
REQ-023 In TYPE, key_valid with key_bksp=1 and cursor>0 SHALL decrement cursor and clear err_mask[cursor-1]; err_cnt SHALL NOT decrement; with cursor=0 no effect.
REQ-024 key_valid outside TYPE SHALL have no effect on any output.
REQ-025 Response latency SHALL be one cycle: outputs reflect a key event on the edge after key_valid is sampled.
REQ-026 key_valid and start in the same TYPE cycle: key processed, start ignored.
REQ-027 text SHALL hold its value in TYPE, DONE and IDLE; unaffected by keys.

Reset
REQ-028 rst SHALL take priority over all inputs, at any state including mid-GEN.
REQ-029 On rst: state IDLE, text=0 (all 'A'), cursor=0, err_mask=0, err_cnt=0, busy=0, done=0, LFSR=SEED.

Verification
REQ-030 rst, start pulse -> busy high 25 cycles, then TYPE; every slot in 0..25; two runs from reset with identical start timing give identical text.
REQ-031 Type all 25 correct letters, one per 3 cycles -> cursor 1..25 stepwise, err_mask=0, err_cnt=0, done=1 one cycle after 25th key.
REQ-032 Type wrong letter at slot 0, backspace, correct letter -> err_mask[0] 1 then 0 then 0, err_cnt stays 1, cursor 1,0,1.
REQ-033 Backspace at cursor 0 and keys during GEN/IDLE -> no output change; key_code 31 in TYPE -> counted as error.
REQ-034 300 wrong keys with backspaces between -> err_cnt saturates at 255.
REQ-035 rst asserted mid-GEN and mid-TYPE -> all outputs at REQ-029 values next cycle; later start regenerates normally.

Source files
------------

// File: rtl/type_tracker.sv
// Typing-trainer core: generates a pseudo-random target text from an LFSR,
// then scores keystrokes against it with backspace support and error tracking.
module type_tracker #(
  parameter int          LEN  = 25,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  input  logic             key_bksp,
  output logic [5*LEN-1:0] text,
  output logic [4:0]       cursor,
  output logic [LEN-1:0]   err_mask,
  output logic [7:0]       err_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_TYPE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [4:0]     gen_idx_q, gen_idx_d;
  logic [4:0]     text_q [LEN];
  logic [4:0]     text_d [LEN];
  logic [4:0]     cursor_q, cursor_d;
  logic [LEN-1:0] err_mask_q, err_mask_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [4:0]     new_letter;

  // Fold the 6 out-of-range codes back onto A..F so every slot is a letter.
  assign new_letter = (lfsr_q[4:0] >= 5'd26) ? (lfsr_q[4:0] - 5'd26) : lfsr_q[4:0];

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    gen_idx_d  = gen_idx_q;
    text_d     = text_q;
    cursor_d   = cursor_q;
    err_mask_d = err_mask_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_GEN;
          gen_idx_d  = '0;
          cursor_d   = '0;
          err_mask_d = '0;
          err_cnt_d  = '0;
        end
      end
      S_GEN: begin
        text_d[gen_idx_q] = new_letter;
        if (gen_idx_q == 5'(LEN - 1)) begin
          state_d = S_TYPE;
        end else begin
          gen_idx_d = gen_idx_q + 5'd1;
        end
      end
      S_TYPE: begin
        if (key_valid) begin
          if (key_bksp) begin
            if (cursor_q != 5'd0) begin
              cursor_d               = cursor_q - 5'd1;
              err_mask_d[cursor_d]   = 1'b0;
            end
          end else begin
            if (key_code != text_q[cursor_q]) begin
              err_mask_d[cursor_q] = 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end
            cursor_d = cursor_q + 5'd1;
            if (cursor_q == 5'(LEN - 1)) begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_GEN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      gen_idx_q  <= '0;
      for (int i = 0; i < LEN; i++) begin
        text_q[i] <= '0;
      end
      cursor_q   <= '0;
      err_mask_q <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      gen_idx_q  <= gen_idx_d;
      text_q     <= text_d;
      cursor_q   <= cursor_d;
      err_mask_q <= err_mask_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  for (genvar gi = 0; gi < LEN; gi++) begin : g_text
    assign text[gi*5 +: 5] = text_q[gi];
  end

  assign cursor   = cursor_q;
  assign err_mask = err_mask_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_type_tracker.sv
// Randomized scoreboard bench for type_tracker: a behavioural model predicts
// every cycle's outputs, a monitor compares them one cycle after issue.
module tb_type_tracker;
  localparam int          LEN  = 25;
  localparam logic [15:0] SEED = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             key_valid = 1'b0;
  logic [4:0]       key_code = '0;
  logic             key_bksp = 1'b0;
  logic [5*LEN-1:0] text;
  logic [4:0]       cursor;
  logic [LEN-1:0]   err_mask;
  logic [7:0]       err_cnt;
  logic             busy;
  logic             done;

  type_tracker #(.LEN(LEN), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
    .key_code(key_code), .key_bksp(key_bksp), .text(text), .cursor(cursor),
    .err_mask(err_mask), .err_cnt(err_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [5*LEN-1:0] text;
    logic [4:0]       cursor;
    logic [LEN-1:0]   mask;
    logic [7:0]       cnt;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: phase names, integer cursor, per-slot letter array
  localparam int P_IDLE = 0, P_GEN = 1, P_TYPE = 2, P_DONE = 3;
  int          m_phase;
  int          m_k;
  int          m_cursor;
  int          m_cnt;
  int          m_text [LEN];
  bit          m_mask [LEN];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic step(input bit r, input bit s, input bit kv, input bit bk, input logic [4:0] kc);
    int   old_phase;
    int   v;
    exp_t e;
    @(negedge clk);
    rst = r; start = s; key_valid = kv; key_bksp = bk; key_code = kc;
    if (r) begin
      m_phase = P_IDLE; m_k = 0; m_cursor = 0; m_cnt = 0; m_lfsr = SEED;
      for (int i = 0; i < LEN; i++) begin m_text[i] = 0; m_mask[i] = 0; end
    end else begin
      old_phase = m_phase;
      if ((old_phase == P_IDLE || old_phase == P_DONE) && s) begin
        m_phase = P_GEN; m_k = 0; m_cursor = 0; m_cnt = 0;
        for (int i = 0; i < LEN; i++) m_mask[i] = 0;
      end else if (old_phase == P_GEN) begin
        v = int'(m_lfsr) % 32;
        m_text[m_k] = (v < 26) ? v : v - 26;
        m_k++;
        if (m_k == LEN) m_phase = P_TYPE;
      end else if (old_phase == P_TYPE && kv) begin
        if (bk) begin
          if (m_cursor > 0) begin
            m_cursor--;
            m_mask[m_cursor] = 0;
          end
        end else begin
          if (int'(kc) != m_text[m_cursor]) begin
            m_mask[m_cursor] = 1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          end
          m_cursor++;
          if (m_cursor == LEN) m_phase = P_DONE;
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    e.cyc    = cyc + 1;
    for (int i = 0; i < LEN; i++) begin
      e.text[i*5 +: 5] = 5'(m_text[i]);
      e.mask[i]        = m_mask[i];
    end
    e.cursor = 5'(m_cursor);
    e.cnt    = 8'(m_cnt);
    e.busy   = (m_phase == P_GEN);
    e.done   = (m_phase == P_DONE);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0);
  endtask

  task automatic key(input logic [4:0] c);
    step(0, 0, 1, 0, c);
  endtask

  task automatic bksp();
    step(0, 0, 1, 1, 5'd0);
  endtask

  task automatic finish_gen();
    while (m_phase == P_GEN) idle(1);
  endtask

  function automatic logic [4:0] wrong_code(input int c);
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(26, 31));
    return 5'((c + 1 + $urandom_range(0, 24)) % 26);
  endfunction

  // Fixed reset-to-start timing so repeated runs must regenerate the same text
  task automatic gen_from_reset();
    step(1, 0, 0, 0, 5'd0);
    step(1, 0, 0, 0, 5'd0);
    key(5'd7);
    bksp();
    idle(3);
    step(0, 1, 0, 0, 5'd0);
    key(5'd3);
    bksp();
    step(0, 1, 0, 0, 5'd0);
    finish_gen();
  endtask

  task automatic random_steps(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4 && m_phase == P_TYPE)      key(5'(m_text[m_cursor]));
      else if (r < 6 && m_phase == P_TYPE) key(wrong_code(m_text[m_cursor]));
      else if (r < 8)                      bksp();
      else if (r == 8)                     step(0, 1, 0, 0, 5'd0);
      else                                 idle(1);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      $display("FAIL missed_check cyc=%0d actual=unchecked required=checked", q[0].cyc);
      miscompares++;
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      bit   bad;
      e = q.pop_front();
      bad = 0;
      vectors++;
      if (text !== e.text) begin
        $display("FAIL text cyc=%0d actual=%h required=%h", cyc, text, e.text); bad = 1;
      end
      if (cursor !== e.cursor) begin
        $display("FAIL cursor cyc=%0d actual=%0d required=%0d", cyc, cursor, e.cursor); bad = 1;
      end
      if (err_mask !== e.mask) begin
        $display("FAIL err_mask cyc=%0d actual=%h required=%h", cyc, err_mask, e.mask); bad = 1;
      end
      if (err_cnt !== e.cnt) begin
        $display("FAIL err_cnt cyc=%0d actual=%0d required=%0d", cyc, err_cnt, e.cnt); bad = 1;
      end
      if (busy !== e.busy) begin
        $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, busy, e.busy); bad = 1;
      end
      if (done !== e.done) begin
        $display("FAIL done cyc=%0d actual=%b required=%b", cyc, done, e.done); bad = 1;
      end
      if (bad) miscompares++;
      $display("vec %0d cyc=%0d cursor=%0d err_cnt=%0d busy=%b done=%b", vectors, cyc, cursor, err_cnt, busy, done);
    end
  end

  initial begin
    // Generation with keys/starts ignored in IDLE and GEN
    gen_from_reset();

    // Backspace at cursor 0, then a clean round typed one key per 3 cycles
    bksp();
    for (int i = 0; i < LEN; i++) begin
      if (i == 10) step(0, 1, 1, 0, 5'(m_text[i]));
      else         key(5'(m_text[i]));
      idle(2);
    end
    key(5'd0);
    bksp();
    idle(2);

    // New round from DONE: wrong, backspace, correct; then invalid code 31
    step(0, 1, 0, 0, 5'd0);
    finish_gen();
    key(5'((m_text[0] + 1) % 26));
    idle(1);
    bksp();
    idle(1);
    key(5'(m_text[0]));
    key(5'd31);
    random_steps(150);

    // Saturation: wrong keys with backspaces between
    step(1, 0, 0, 0, 5'd0);
    step(0, 1, 0, 0, 5'd0);
    finish_gen();
    for (int i = 0; i < 300; i++) begin
      key(wrong_code(m_text[0]));
      bksp();
    end
    key(wrong_code(m_text[0]));

    // Reset mid-TYPE, then mid-GEN, then regenerate with the original timing
    step(1, 0, 0, 0, 5'd0);
    idle(1);
    step(0, 1, 0, 0, 5'd0);
    idle(10);
    step(1, 0, 0, 0, 5'd0);
    idle(1);
    gen_from_reset();
    for (int i = 0; i < 400 && m_phase != P_DONE; i++) begin
      if ($urandom_range(0, 2) != 0) key(5'(m_text[m_cursor]));
      else                           key(wrong_code(m_text[m_cursor]));
    end
    idle(3);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      $display("FAIL queue_drain actual=%0d required=0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
